// File: rtl/rx_credit_manager.sv
// Receiver-side credit manager: tracks receive-buffer occupancy, gathers freed
// slots and returns them to the far-end transmitter as batched credit messages.
module rx_credit_manager #(
    parameter int BUF_DEPTH = 16,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 64,
    localparam int CW       = $clog2(BUF_DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_link_up,
    input  logic          i_alloc,
    input  logic          i_free,
    output logic          o_credit_valid,
    output logic [CW-1:0] o_credit_cnt,
    input  logic          i_credit_ready,
    output logic [CW-1:0] o_occupancy,
    output logic [CW-1:0] o_pending,
    output logic          o_overrun,
    output logic          o_underrun,
    input  logic          i_err_clr
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_C      = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] THRESHOLD_C = CW'(THRESHOLD);
    localparam logic [TW-1:0] TIMER_MAX_C = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ACCUM = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t          state_r;
    logic            valid_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   occ_r;
    logic [CW-1:0]   pend_r;
    logic [TW-1:0]   timer_r;
    logic            overrun_r;
    logic            underrun_r;

    logic            active_s;
    logic            free_acc_s;
    logic            ovr_set_s;
    logic            und_set_s;
    logic [CW-1:0]   occ_next_s;
    logic [CW-1:0]   pend_next_s;
    logic            fire_s;

    // Per-cycle occupancy/pending update and error detection
    always_comb begin
        active_s    = 1'b0;
        free_acc_s  = 1'b0;
        ovr_set_s   = 1'b0;
        und_set_s   = 1'b0;
        occ_next_s  = occ_r;
        pend_next_s = pend_r;
        fire_s      = 1'b0;

        if ((state_r != IDLE) && i_link_up) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end

        // A free paired with an alloc is always real, even at occupancy 0
        free_acc_s = active_s && i_free && (i_alloc || (occ_r != {CW{1'b0}}));
        ovr_set_s  = active_s && i_alloc && !i_free && (occ_r == FULL_C);
        und_set_s  = active_s && i_free && !i_alloc && (occ_r == {CW{1'b0}});

        if (i_alloc && !i_free) begin
            if (occ_r != FULL_C) begin
                occ_next_s = occ_r + CW'(1);
            end else begin
                occ_next_s = occ_r;
            end
        end else if (i_free && !i_alloc) begin
            if (occ_r != {CW{1'b0}}) begin
                occ_next_s = occ_r - CW'(1);
            end else begin
                occ_next_s = occ_r;
            end
        end else begin
            occ_next_s = occ_r;
        end

        pend_next_s = pend_r + {{(CW-1){1'b0}}, free_acc_s};

        if ((pend_next_s >= THRESHOLD_C) ||
            ((pend_r != {CW{1'b0}}) && (timer_r == TIMER_MAX_C))) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Credit-return FSM with registered message outputs and counters
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            occ_r   <= {CW{1'b0}};
            pend_r  <= {CW{1'b0}};
            timer_r <= {TW{1'b0}};
        end else if ((state_r != IDLE) && !i_link_up) begin
            // Link loss is the only case where a pending message is withdrawn
            state_r <= IDLE;
            valid_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            occ_r   <= {CW{1'b0}};
            pend_r  <= {CW{1'b0}};
            timer_r <= {TW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    occ_r   <= {CW{1'b0}};
                    pend_r  <= {CW{1'b0}};
                    timer_r <= {TW{1'b0}};
                    if (i_link_up) begin
                        state_r <= INIT;
                    end
                end
                INIT: begin
                    occ_r   <= occ_next_s;
                    pend_r  <= pend_next_s;
                    timer_r <= {TW{1'b0}};
                    // First INIT cycle raises the full-depth advertisement
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        cnt_r   <= FULL_C;
                    end else if (i_credit_ready) begin
                        valid_r <= 1'b0;
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    occ_r <= occ_next_s;
                    if (fire_s) begin
                        state_r <= SEND;
                        valid_r <= 1'b1;
                        cnt_r   <= pend_next_s;
                        pend_r  <= {CW{1'b0}};
                        timer_r <= {TW{1'b0}};
                    end else begin
                        pend_r <= pend_next_s;
                        if (pend_r != {CW{1'b0}}) begin
                            timer_r <= timer_r + TW'(1);
                        end else begin
                            timer_r <= {TW{1'b0}};
                        end
                    end
                end
                SEND: begin
                    occ_r   <= occ_next_s;
                    pend_r  <= pend_next_s;
                    timer_r <= {TW{1'b0}};
                    if (i_credit_ready) begin
                        valid_r <= 1'b0;
                        state_r <= ACCUM;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    occ_r   <= {CW{1'b0}};
                    pend_r  <= {CW{1'b0}};
                    timer_r <= {TW{1'b0}};
                end
            endcase
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (i_err_clr) begin
                overrun_r <= 1'b0;
            end
            if (und_set_s) begin
                underrun_r <= 1'b1;
            end else if (i_err_clr) begin
                underrun_r <= 1'b0;
            end
        end
    end

    assign o_credit_valid = valid_r;
    assign o_credit_cnt   = cnt_r;
    assign o_occupancy    = occ_r;
    assign o_pending      = pend_r;
    assign o_overrun      = overrun_r;
    assign o_underrun     = underrun_r;

endmodule

// File: tb/tb_rx_credit_manager.sv
// Directed self-checking bench for rx_credit_manager (BUF_DEPTH 16, THRESHOLD 4, TIMEOUT 64).
module tb_rx_credit_manager;

    logic       i_clk;
    logic       i_arst_n;
    logic       i_link_up;
    logic       i_alloc;
    logic       i_free;
    logic       o_credit_valid;
    logic [4:0] o_credit_cnt;
    logic       i_credit_ready;
    logic [4:0] o_occupancy;
    logic [4:0] o_pending;
    logic       o_overrun;
    logic       o_underrun;
    logic       i_err_clr;

    int errors;
    int checks;

    rx_credit_manager #(
        .BUF_DEPTH(16),
        .THRESHOLD(4),
        .TIMEOUT(64)
    ) dut (
        .i_clk          (i_clk),
        .i_arst_n       (i_arst_n),
        .i_link_up      (i_link_up),
        .i_alloc        (i_alloc),
        .i_free         (i_free),
        .o_credit_valid (o_credit_valid),
        .o_credit_cnt   (o_credit_cnt),
        .i_credit_ready (i_credit_ready),
        .o_occupancy    (o_occupancy),
        .o_pending      (o_pending),
        .o_overrun      (o_overrun),
        .o_underrun     (o_underrun),
        .i_err_clr      (i_err_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0; i_link_up = 1'b0; i_alloc = 1'b0; i_free = 1'b0;
        i_credit_ready = 1'b0; i_err_clr = 1'b0;
        step(); step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", o_credit_valid); end
        checks++; if (o_credit_cnt !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", o_credit_cnt); end
        checks++; if (o_occupancy !== 5'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", o_occupancy); end
        checks++; if (o_pending !== 5'd0) begin errors++; $display("FAIL rst_pend: got %0d want 0", o_pending); end
        checks++; if (o_overrun !== 1'b0 || o_underrun !== 1'b0) begin errors++; $display("FAIL rst_flags: got %0b%0b want 00", o_overrun, o_underrun); end
        i_arst_n = 1'b1;
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0b want 0", o_credit_valid); end
    endtask

    task automatic test_link_up();
        i_link_up = 1'b1; i_credit_ready = 1'b1;
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL linkup_lat: got %0b want 0", o_credit_valid); end
        step();
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd16) begin errors++; $display("FAIL init_msg: got v=%0b cnt=%0d want v=1 cnt=16", o_credit_valid, o_credit_cnt); end
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL init_xfer: got %0b want 0", o_credit_valid); end
    endtask

    task automatic test_threshold();
        i_alloc = 1'b1;
        repeat (16) step();
        i_alloc = 1'b0;
        checks++; if (o_occupancy !== 5'd16 || o_credit_valid !== 1'b0) begin errors++; $display("FAIL fill: got occ=%0d v=%0b want occ=16 v=0", o_occupancy, o_credit_valid); end
        i_free = 1'b1;
        step();
        checks++; if (o_occupancy !== 5'd15 || o_pending !== 5'd1 || o_credit_valid !== 1'b0) begin errors++; $display("FAIL free1: got occ=%0d pend=%0d v=%0b want 15 1 0", o_occupancy, o_pending, o_credit_valid); end
        repeat (3) step();
        i_free = 1'b0;
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd4) begin errors++; $display("FAIL thr_msg: got v=%0b cnt=%0d want v=1 cnt=4", o_credit_valid, o_credit_cnt); end
        checks++; if (o_occupancy !== 5'd12 || o_pending !== 5'd0) begin errors++; $display("FAIL thr_cnt: got occ=%0d pend=%0d want 12 0", o_occupancy, o_pending); end
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL thr_xfer: got %0b want 0", o_credit_valid); end
    endtask

    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        i_free = 1'b1;
        step();
        i_free = 1'b0;
        checks++; if (o_pending !== 5'd1 || o_occupancy !== 5'd11) begin errors++; $display("FAIL to_start: got pend=%0d occ=%0d want 1 11", o_pending, o_occupancy); end
        for (int i = 0; i < 63; i++) begin
            step();
            if (o_credit_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_early: got valid=%0b want 0", seen); end
        step();
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd1 || o_pending !== 5'd0) begin errors++; $display("FAIL to_msg: got v=%0b cnt=%0d pend=%0d want 1 1 0", o_credit_valid, o_credit_cnt, o_pending); end
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL to_xfer: got %0b want 0", o_credit_valid); end
    endtask

    task automatic test_stall();
        i_credit_ready = 1'b0;
        i_free = 1'b1;
        repeat (4) step();
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd4 || o_occupancy !== 5'd7) begin errors++; $display("FAIL st_msg: got v=%0b cnt=%0d occ=%0d want 1 4 7", o_credit_valid, o_credit_cnt, o_occupancy); end
        repeat (3) step();
        i_free = 1'b0;
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd4 || o_pending !== 5'd3 || o_occupancy !== 5'd4) begin errors++; $display("FAIL st_hold: got v=%0b cnt=%0d pend=%0d occ=%0d want 1 4 3 4", o_credit_valid, o_credit_cnt, o_pending, o_occupancy); end
        repeat (2) step();
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd4) begin errors++; $display("FAIL st_stable: got v=%0b cnt=%0d want 1 4", o_credit_valid, o_credit_cnt); end
        i_credit_ready = 1'b1;
        step();
        checks++; if (o_credit_valid !== 1'b0 || o_pending !== 5'd3) begin errors++; $display("FAIL st_xfer: got v=%0b pend=%0d want 0 3", o_credit_valid, o_pending); end
        i_free = 1'b1;
        step();
        i_free = 1'b0;
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd4 || o_pending !== 5'd0 || o_occupancy !== 5'd3) begin errors++; $display("FAIL st_next: got v=%0b cnt=%0d pend=%0d occ=%0d want 1 4 0 3", o_credit_valid, o_credit_cnt, o_pending, o_occupancy); end
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL st_next_xfer: got %0b want 0", o_credit_valid); end
    endtask

    task automatic test_errors();
        i_alloc = 1'b1;
        repeat (13) step();
        checks++; if (o_occupancy !== 5'd16 || o_overrun !== 1'b0) begin errors++; $display("FAIL err_fill: got occ=%0d ovr=%0b want 16 0", o_occupancy, o_overrun); end
        i_free = 1'b1;
        step();
        i_alloc = 1'b0; i_free = 1'b0;
        checks++; if (o_occupancy !== 5'd16 || o_overrun !== 1'b0 || o_pending !== 5'd1) begin errors++; $display("FAIL err_both: got occ=%0d ovr=%0b pend=%0d want 16 0 1", o_occupancy, o_overrun, o_pending); end
        i_alloc = 1'b1;
        step();
        i_alloc = 1'b0;
        checks++; if (o_overrun !== 1'b1 || o_occupancy !== 5'd16) begin errors++; $display("FAIL err_ovr: got ovr=%0b occ=%0d want 1 16", o_overrun, o_occupancy); end
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL err_clr_ovr: got %0b want 0", o_overrun); end
        i_free = 1'b1;
        repeat (16) step();
        checks++; if (o_occupancy !== 5'd0 || o_pending !== 5'd1 || o_underrun !== 1'b0) begin errors++; $display("FAIL err_drain: got occ=%0d pend=%0d und=%0b want 0 1 0", o_occupancy, o_pending, o_underrun); end
        step();
        checks++; if (o_underrun !== 1'b1 || o_pending !== 5'd1 || o_occupancy !== 5'd0) begin errors++; $display("FAIL err_und: got und=%0b pend=%0d occ=%0d want 1 1 0", o_underrun, o_pending, o_occupancy); end
        i_err_clr = 1'b1;
        step();
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL err_set_prio: got %0b want 1", o_underrun); end
        i_free = 1'b0;
        step();
        i_err_clr = 1'b0;
        checks++; if (o_underrun !== 1'b0 || o_overrun !== 1'b0) begin errors++; $display("FAIL err_clr_all: got ovr=%0b und=%0b want 0 0", o_overrun, o_underrun); end
    endtask

    task automatic test_abort();
        i_free = 1'b1;
        step();
        i_free = 1'b0;
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ab_und: got %0b want 1", o_underrun); end
        i_credit_ready = 1'b0;
        i_alloc = 1'b1;
        repeat (4) step();
        i_alloc = 1'b0;
        i_free = 1'b1;
        repeat (3) step();
        i_free = 1'b0;
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd4 || o_occupancy !== 5'd1 || o_pending !== 5'd0) begin errors++; $display("FAIL ab_send: got v=%0b cnt=%0d occ=%0d pend=%0d want 1 4 1 0", o_credit_valid, o_credit_cnt, o_occupancy, o_pending); end
        i_link_up = 1'b0;
        step();
        checks++; if (o_credit_valid !== 1'b0 || o_credit_cnt !== 5'd0 || o_occupancy !== 5'd0 || o_pending !== 5'd0) begin errors++; $display("FAIL ab_clear: got v=%0b cnt=%0d occ=%0d pend=%0d want 0 0 0 0", o_credit_valid, o_credit_cnt, o_occupancy, o_pending); end
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ab_flag_kept: got %0b want 1", o_underrun); end
        i_link_up = 1'b1;
        step();
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL ab_relink_lat: got %0b want 0", o_credit_valid); end
        step();
        checks++; if (o_credit_valid !== 1'b1 || o_credit_cnt !== 5'd16) begin errors++; $display("FAIL ab_reinit: got v=%0b cnt=%0d want 1 16", o_credit_valid, o_credit_cnt); end
    endtask

    task automatic test_async_reset();
        #2;
        i_arst_n = 1'b0;
        #1;
        checks++; if (o_credit_valid !== 1'b0 || o_credit_cnt !== 5'd0 || o_underrun !== 1'b0) begin errors++; $display("FAIL arst_mid: got v=%0b cnt=%0d und=%0b want 0 0 0", o_credit_valid, o_credit_cnt, o_underrun); end
        #5;
        i_arst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_link_up();
        test_threshold();
        test_timeout();
        test_stall();
        test_errors();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
